uart_msg_scheduler: RTL

//  Shares the single uart_tx between message sources (fault detection, node/path status, CPU path report).

---
 rtl/astro_msg_pkg.sv | 20 ++
 rtl/uart_msg_scheduler_if.sv | 11 +
 rtl/uart_msg_scheduler_rr_arbiter.sv | 45 ++++
 rtl/uart_msg_scheduler.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/astro_msg_pkg.sv
// Shared definitions for the UART message path: scheduler FSM encoding,
// message size defaults and the framing bytes used by every message producer.
package astro_msg_pkg;

  localparam int MAX_BYTES_DEF = 8;
  localparam int LEN_W_DEF     = 4;

  localparam logic [7:0] MSG_TERM = 8'h23;  // '#'
  localparam logic [7:0] MSG_SEP  = 8'h2D;  // '-'

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_FINISH
  } sched_state_e;

endpackage

// File: rtl/uart_msg_scheduler_if.sv
// Byte handshake between the message scheduler (master) and uart_tx (slave).
interface uart_msg_scheduler_if;

  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;

  modport master (output tx_byte, output tx_start, input tx_busy);
  modport slave  (input tx_byte, input tx_start, output tx_busy);

endinterface

// File: rtl/uart_msg_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or after the pointer, wrapping.
// UART_SCHED_FAULT_PRIO_EN: request 0 (fault) wins outright whenever it is set.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  assign o_valid = |i_req;

  always_comb begin : rotate
    int j;
    j       = 0;
    w_cand  = '0;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
`ifdef UART_SCHED_FAULT_PRIO_EN
    if (i_req[0]) begin
      o_grant[0] = 1'b1;
      w_found    = 1'b1;
    end
`else
`endif
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      w_cand = IDX_W'(j);
      if (!w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_msg_scheduler.sv
// Shares one uart_tx between N_REQ message sources: arbitrates, latches a message
// and sends it byte by byte. UART_SCHED_FAULT_PRIO_EN gives source 0 absolute priority.
module uart_msg_scheduler
  import astro_msg_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int BUSY_TMO  = 1024
) (
  input  logic                         clk_50M,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*MAX_BYTES*8-1:0] msg_data,
  input  logic [N_REQ*LEN_W-1:0]       msg_len,
  output logic [N_REQ-1:0]             ack,
  output logic [N_REQ-1:0]             done,
  uart_msg_scheduler_if.master         tx,
  output logic                         sched_busy,
  output logic                         tmo_err
);

  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BYTE_IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int TMO_W      = $clog2(BUSY_TMO);
  localparam int MSG_W      = MAX_BYTES * 8;

  sched_state_e r_state, w_state_nxt;

  logic [IDX_W-1:0]               r_ptr, r_winner, w_win_idx, w_ptr_nxt;
  logic [LEN_W-1:0]               r_len, r_cnt, w_len_sel, w_len_clamp;
  logic [TMO_W-1:0]               r_timer;
  logic [MAX_BYTES-1:0][7:0]      r_buf;
  logic [7:0]                     r_tx_byte;
  logic [N_REQ-1:0]               r_ack, r_done, w_grant, w_ack_nxt, w_done_nxt;
  logic                           r_tx_start, r_tmo, w_start_nxt, w_tmo_nxt, w_any_req;
  logic [BYTE_IDX_W-1:0]          w_byte_idx;
  logic [MSG_W-1:0]               w_msg [N_REQ];
  logic [LEN_W-1:0]               w_len [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_src
    assign w_msg[i] = msg_data[i*MSG_W +: MSG_W];
    assign w_len[i] = msg_len[i*LEN_W +: LEN_W];
  end

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win_idx),
    .o_valid (w_any_req)
  );

  assign w_len_sel   = w_len[w_win_idx];
  assign w_len_clamp = (w_len_sel > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : w_len_sel;
  assign w_byte_idx  = r_cnt[BYTE_IDX_W-1:0];
  assign w_ptr_nxt   = (r_winner == IDX_W'(N_REQ-1)) ? '0 : r_winner + 1'b1;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_start_nxt = 1'b0;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      S_IDLE: if (w_any_req) begin
        w_state_nxt = S_GRANT;
        w_ack_nxt   = w_grant;
      end
      S_GRANT:   w_state_nxt = (r_len == '0) ? S_FINISH : S_START;
      // Never overlap a frame: hold the strobe until uart_tx is idle.
      S_START: if (!tx.tx_busy) begin
        w_start_nxt = 1'b1;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: if (tx.tx_busy) begin
        w_state_nxt = S_WAIT_LO;
      end else if (r_timer == TMO_W'(BUSY_TMO-1)) begin
        w_tmo_nxt   = 1'b1;
        w_state_nxt = S_FINISH;
      end
      S_WAIT_LO: if (!tx.tx_busy) begin
        w_state_nxt = ((r_cnt + 1'b1) == r_len) ? S_FINISH : S_START;
      end
      S_FINISH: begin
        w_done_nxt[r_winner] = 1'b1;
        w_state_nxt          = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the message buffer is reset too, so a dropped message never leaks onto tx_byte.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_winner   <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_buf      <= '0;
      r_tx_byte  <= '0;
      r_ack      <= '0;
      r_done     <= '0;
      r_tx_start <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_ack      <= w_ack_nxt;
      r_done     <= w_done_nxt;
      r_tx_start <= w_start_nxt;
      r_tmo      <= w_tmo_nxt;
      case (r_state)
        S_IDLE: if (w_any_req) begin
          r_winner <= w_win_idx;
          r_buf    <= w_msg[w_win_idx];
          r_len    <= w_len_clamp;
          r_cnt    <= '0;
        end
        S_START: begin
          r_tx_byte <= r_buf[w_byte_idx];
          r_timer   <= '0;
        end
        S_WAIT_HI: r_timer <= r_timer + 1'b1;
        S_WAIT_LO: if (!tx.tx_busy) r_cnt <= r_cnt + 1'b1;
        S_FINISH:  r_ptr <= w_ptr_nxt;
        default: ;
      endcase
    end
  end

  assign ack         = r_ack;
  assign done        = r_done;
  assign tmo_err     = r_tmo;
  assign tx.tx_start = r_tx_start;
  assign tx.tx_byte  = r_tx_byte;
  assign sched_busy  = (r_state != S_IDLE);

endmodule
